fft_bin_capture: RTL and testbench
==================================

Name: fft_bin_capture

Overview:
- Sink for the FFT core's streaming output: consumes `read_valid` / `counter_addr` / real / imag bin beats.
- Computes a per-bin magnitude estimate and stores one full frame in a ping-pong buffer.
- Tracks the peak bin of each frame.
- Exposes completed frames to the pitch-detection logic through a registered random-access read port and a frame-complete pulse.

Parameters:
- LOG2N, 10, log2 of FFT length N; frame is bins 0..N-1.
- DW, 18, signed width of real/imag input components.
- MW, 19 (DW+1), unsigned magnitude width stored per bin.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- read_valid  in  1  input beat qualifier; one bin per cycle when high.
- counter_addr  in  LOG2N  bin index of the current beat.
- data_real_in  in  DW  signed real part of the bin.
- data_imag_in  in  DW  signed imaginary part of the bin.
- rd_addr  in  LOG2N  bin address for readout of the last completed frame.
- rd_data  out  MW  magnitude at rd_addr; 1-cycle registered latency.
- peak_bin  out  LOG2N  index of the largest magnitude in the last completed frame.
- peak_mag  out  MW  magnitude of peak_bin.
- frame_valid  out  1  one-cycle pulse when a frame completes; bank, peak and outputs updated the same edge.
- frame_err  out  1  one-cycle pulse when a capture is aborted by an out-of-order address.
- busy  out  1  high while in CAPTURE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, expected address=0, write bank=0, read bank=1, rd_data=0, peak_bin=0, peak_mag=0, frame_valid=0, frame_err=0, busy=0. Buffer contents undefined after reset.
- Magnitude (default): |re|+|im|, each abs taken into DW bits unsigned, so abs(-2^(DW-1)) = 2^(DW-1). Sum is MW bits, no saturation needed; max 2^DW.
- Magnitude is computed combinationally and written on the same edge the beat is accepted.
- State IDLE:
  - Ignores beats with counter_addr != 0.
  - On read_valid && addr==0: write bin 0, expected=1, go to CAPTURE, busy=1.
- State CAPTURE:
  - read_valid low: hold; gaps of any length allowed.
  - read_valid && addr==expected: write bin, expected+1.
  - Running peak: candidate only for bins 1..N/2-1; DC and the upper half are written but not considered.
  - Strict greater-than compare, so ties keep the lower bin. Running peak initialised to bin 1 on its write.
  - read_valid && addr==N-1 == expected: write bin, then on the same edge:
    - pulse frame_valid;
    - swap banks (read bank = just-written bank);
    - latch peak_bin / peak_mag;
    - go to IDLE.
  - read_valid && addr!=expected: abort; pulse frame_err; banks and peak outputs unchanged.
    - If the offending addr==0, the beat is treated as the start of a new frame the same cycle (stay CAPTURE, expected=1).
    - Otherwise go to IDLE.
- Readout:
  - rd_data <= mem[read bank][rd_addr] every cycle, no enable.
  - Reads never see the bank being written.
  - Reading at the same edge as a bank swap returns the old bank's data; the new bank is visible from the next cycle.
- Reset mid-CAPTURE: partial frame discarded; no frame_valid or frame_err pulse.
- Wrap: expected is LOG2N bits; it is never compared past N-1 because completion forces IDLE.
- Memory: 2*N x MW, inferable as simple dual-port RAM (one write port, one read port).

Optional Feature:
- MAG_ALPHA_BETA_EN defined: magnitude = max(|re|,|im|) + (min(|re|,|im|) >> 1), alpha-max-beta-min approximation with about 12% peak error versus |re|+|im|'s about 41%. Width stays MW.
- MAG_ALPHA_BETA_EN undefined: |re|+|im| as above. All other timing is identical.

Test Plan:
- Reset, then stream bins 0..1023 back-to-back with bin k: re=k, im=-k -> frame_valid pulses once on the cycle after addr 1023 is accepted. rd_addr=5 gives rd_data=10 one cycle later. peak_bin=511, peak_mag=1022.
- Same frame with 3-cycle read_valid gaps after every 100 beats -> identical results; busy stays high throughout the capture.
- Bin 200 and bin 300 both re=1000, im=0, all others 0 -> peak_bin=200. Bin 0 re=5000 -> ignored. Bin 700 re=9000 -> ignored.
- Mid-frame, jump from addr 40 to addr 42 -> frame_err single pulse, no frame_valid, previous frame's rd_data and peak unchanged. Next addr 0 restarts capture.
- Abort by addr 0 at position 500, then a full frame 1..1023 -> exactly one frame_valid, data from the second frame only.
- re=-131072, im=-131072 at bin 3 -> rd_data=262144 by default; with MAG_ALPHA_BETA_EN defined -> 196608.

Source files
------------

// File: rtl/fft_bin_capture.sv
// Frame capture sink for the FFT output stream: per-bin magnitude, ping-pong storage, peak tracking.
// Define MAG_ALPHA_BETA_EN to use the alpha-max-beta-min magnitude instead of |re|+|im|.
module fft_bin_capture #(
  parameter int LOG2N = 10,
  parameter int DW    = 18,
  parameter int MW    = DW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid,
  input  logic [LOG2N-1:0]     counter_addr,
  input  logic signed [DW-1:0] data_real_in,
  input  logic signed [DW-1:0] data_imag_in,
  input  logic [LOG2N-1:0]     rd_addr,
  output logic [MW-1:0]        rd_data,
  output logic [LOG2N-1:0]     peak_bin,
  output logic [MW-1:0]        peak_mag,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CAPTURE = 1'b1;

  logic [0:0]       state;
  logic [LOG2N-1:0] expected;
  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] run_bin;
  logic [MW-1:0]    run_mag;

  logic [MW-1:0] mem [0:2*(1<<LOG2N)-1];

  logic [DW-1:0] abs_re;
  logic [DW-1:0] abs_im;
  logic [MW-1:0] mag;

  logic addr_hit;
  logic start;
  logic advance;
  logic mismatch;
  logic last;
  logic candidate;
  logic we;

  // Two's-complement negate kept in DW unsigned bits, so the most negative value maps to 2^(DW-1).
  always_comb begin
    abs_re = data_real_in[DW-1] ? (~data_real_in + 1'b1) : data_real_in;
    abs_im = data_imag_in[DW-1] ? (~data_imag_in + 1'b1) : data_imag_in;
  end

`ifdef MAG_ALPHA_BETA_EN
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

  always_comb begin
    if (abs_re >= abs_im) begin
      hi = abs_re;
      lo = abs_im;
    end else begin
      hi = abs_im;
      lo = abs_re;
    end
    mag = {1'b0, hi} + {1'b0, (lo >> 1)};
  end
`else
  always_comb begin
    mag = {1'b0, abs_re} + {1'b0, abs_im};
  end
`endif

  // Address 0 always (re)starts a frame; in CAPTURE it can never match expected, so it also flags an abort.
  always_comb begin
    addr_hit  = (counter_addr == expected);
    start     = read_valid && (counter_addr == '0);
    advance   = read_valid && (state == CAPTURE) && addr_hit;
    mismatch  = read_valid && (state == CAPTURE) && !addr_hit;
    last      = advance && (counter_addr == '1);
    candidate = (counter_addr != '0) && !counter_addr[LOG2N-1];
    we        = start || advance;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_bank, counter_addr}] <= mag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      expected    <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      rd_data     <= '0;
      peak_bin    <= '0;
      peak_mag    <= '0;
      run_bin     <= '0;
      run_mag     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rd_data     <= mem[{rd_bank, rd_addr}];
      frame_valid <= 1'b0;
      frame_err   <= mismatch;

      if (start) begin
        state    <= CAPTURE;
        expected <= LOG2N'(1);
      end else if (advance) begin
        if (last) begin
          state       <= IDLE;
          expected    <= '0;
          frame_valid <= 1'b1;
          wr_bank     <= ~wr_bank;
          rd_bank     <= wr_bank;
          peak_bin    <= run_bin;
          peak_mag    <= run_mag;
        end else begin
          expected <= expected + LOG2N'(1);
        end

        // Strict compare keeps the lower bin on ties.
        if (counter_addr == LOG2N'(1)) begin
          run_bin <= counter_addr;
          run_mag <= mag;
        end else if (candidate && (mag > run_mag)) begin
          run_bin <= counter_addr;
          run_mag <= mag;
        end
      end else if (mismatch) begin
        state    <= IDLE;
        expected <= '0;
      end
    end
  end

  assign busy = (state == CAPTURE);

endmodule

// File: tb/tb_fft_bin_capture.sv
// Scoreboard bench for fft_bin_capture: stimulus queues expected frame/abort/read results, a monitor pops them.
module tb_fft_bin_capture;

  localparam int LOG2N = 10;
  localparam int DW    = 18;
  localparam int MW    = 19;

`ifdef MAG_ALPHA_BETA_EN
  localparam int EXP3 = 196608;
`else
  localparam int EXP3 = 262144;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 read_valid;
  logic [LOG2N-1:0]     counter_addr;
  logic signed [DW-1:0] data_real_in;
  logic signed [DW-1:0] data_imag_in;
  logic [LOG2N-1:0]     rd_addr;
  logic [MW-1:0]        rd_data;
  logic [LOG2N-1:0]     peak_bin;
  logic [MW-1:0]        peak_mag;
  logic                 frame_valid;
  logic                 frame_err;
  logic                 busy;

  fft_bin_capture #(.LOG2N(LOG2N), .DW(DW), .MW(MW)) dut (
    .clk(clk), .reset(reset), .read_valid(read_valid), .counter_addr(counter_addr),
    .data_real_in(data_real_in), .data_imag_in(data_imag_in), .rd_addr(rd_addr),
    .rd_data(rd_data), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int mag;
  } pk_t;

  pk_t fv_q[$];
  int  fe_q[$];
  int  rd_q[$];

  int  errors = 0;
  int  checks = 0;
  logic rd_req = 1'b0;
  logic rd_chk = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_chk <= rd_req;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_valid) begin
        if (fv_q.size() == 0) begin
          check("frame_valid_unexpected", 1, 0);
        end else begin
          pk_t e;
          e = fv_q.pop_front();
          check("peak_bin", peak_bin, e.bin);
          check("peak_mag", peak_mag, e.mag);
        end
      end
      if (frame_err) begin
        check("frame_err_expected", fe_q.size() > 0, 1);
        if (fe_q.size() > 0) void'(fe_q.pop_front());
      end
      if (rd_chk) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          int e;
          e = rd_q.pop_front();
          check("rd_data", rd_data, e);
        end
      end
    end
  end

  task automatic drive(input bit v, input int a, input int re, input int im,
                       input bit rq, input int ra, input int er);
    @(posedge clk);
    #1;
    read_valid   = v;
    counter_addr = a[LOG2N-1:0];
    data_real_in = re[DW-1:0];
    data_imag_in = im[DW-1:0];
    rd_req       = rq;
    rd_addr      = ra[LOG2N-1:0];
    if (rq) rd_q.push_back(er);
  endtask

  task automatic beat(input int a, input int re, input int im);
    drive(1'b1, a, re, im, 1'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic rd(input int a, input int e);
    drive(1'b0, 0, 0, 0, 1'b1, a, e);
  endtask

  task automatic chk_busy(input string name, input int e);
    @(negedge clk);
    check(name, busy, e);
  endtask

  initial begin
    reset = 1'b1;
    read_valid = 1'b0;
    counter_addr = '0;
    data_real_in = '0;
    data_imag_in = '0;
    rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rd_data", rd_data, 0);
    check("reset_peak_bin", peak_bin, 0);
    check("reset_peak_mag", peak_mag, 0);
    check("reset_frame_valid", frame_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Ramp frame: mag(k) = 2k, peak restricted to bins 1..511.
    fv_q.push_back('{511, 1022});
    for (int k = 0; k < 1024; k++) beat(k, k, -k);
    rd(5, 10);
    rd(0, 0);
    rd(1023, 2046);
    rd(511, 1022);
    idle(1);
    chk_busy("busy_after_frame", 0);

    // Same ramp with 3-cycle gaps.
    fv_q.push_back('{511, 1022});
    for (int k = 0; k < 1024; k++) begin
      beat(k, k, -k);
      if ((k % 100) == 99) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 0, 0, 0, 1'b0, 0, 0);
          chk_busy("busy_gap", 1);
        end
      end
    end
    rd(5, 10);
    rd(1023, 2046);
    idle(1);
    chk_busy("busy_after_gap_frame", 0);

    // Tie at 200/300; DC and upper half excluded; read on the swap edge sees the old bank.
    fv_q.push_back('{200, 1000});
    for (int k = 0; k < 1023; k++) begin
      if (k == 0) beat(k, 5000, 0);
      else if (k == 200 || k == 300) beat(k, 1000, 0);
      else if (k == 700) beat(k, 9000, 0);
      else beat(k, 0, 0);
    end
    drive(1'b1, 1023, 0, 0, 1'b1, 200, 400);
    rd(200, 1000);
    rd(300, 1000);
    rd(0, 5000);
    rd(700, 9000);

    // Skip from 40 to 42 aborts; previous frame stays visible.
    for (int k = 0; k <= 40; k++) beat(k, k, -k);
    fe_q.push_back(1);
    beat(42, 42, -42);
    idle(1);
    chk_busy("busy_after_abort", 0);
    check("peak_bin_held", peak_bin, 200);
    check("peak_mag_held", peak_mag, 1000);
    rd(200, 1000);
    beat(7, 7, 7);
    idle(1);
    chk_busy("busy_idle_ignore", 0);

    // Abort by address 0 at position 500, then bins 1..1023 of the new frame.
    for (int k = 0; k < 500; k++) beat(k, k, -k);
    fe_q.push_back(1);
    fv_q.push_back('{511, 514});
    beat(0, 3, 0);
    for (int k = 1; k < 1024; k++) beat(k, 3, k);
    rd(0, 3);
    rd(5, 8);
    rd(499, 502);
    rd(800, 803);

    // Most negative components at bin 3.
    fv_q.push_back('{3, EXP3});
    for (int k = 0; k < 1024; k++) begin
      if (k == 3) beat(k, -131072, -131072);
      else beat(k, 0, 0);
    end
    rd(3, EXP3);
    rd(4, 0);

    // Reset mid-capture discards the partial frame silently.
    for (int k = 0; k <= 100; k++) beat(k, 50, 50);
    @(posedge clk);
    #1;
    reset = 1'b1;
    read_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_peak_bin", peak_bin, 0);
    check("midreset_peak_mag", peak_mag, 0);
    check("midreset_rd_data", rd_data, 0);
    check("midreset_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    idle(3);
    check("frames_outstanding", fv_q.size(), 0);
    check("aborts_outstanding", fe_q.size(), 0);
    check("reads_outstanding", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
